// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Supports lock for back-to-back bursts and returns read data tagged with the requester id.
module ram_arbiter #(
  parameter int N          = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    lock0,
  input  logic                    lock1,
  input  logic                    rw0,
  input  logic                    rw1,
  input  logic [$clog2(N)-1:0]    addr0,
  input  logic [$clog2(N)-1:0]    addr1,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic                    rd_valid,
  output logic                    rd_id,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    ram_enable,
  output logic                    ram_read_write,
  output logic [$clog2(N)-1:0]    ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_data_in,
  input  logic [DATA_WIDTH-1:0]   ram_data_out
);

  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t                state, state_next;
  logic                  prio, prio_next;
  logic                  issue, issue_id;
  logic                  grant_id;
  logic                  sel_rw;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    state_next = state;
    prio_next  = prio;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_next = prio ? SERVE1 : SERVE0;
        else if (req0)
          state_next = SERVE0;
        else if (req1)
          state_next = SERVE1;
      end
      SERVE0: begin
        if (!(req0 && lock0)) begin
          state_next = IDLE;
          prio_next  = 1'b1;
        end
      end
      SERVE1: begin
        if (!(req1 && lock1)) begin
          state_next = IDLE;
          prio_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every entry into (or stay in) a SERVE state issues exactly one RAM access.
  always_comb begin
    issue     = (state_next != IDLE);
    issue_id  = (state_next == SERVE1);
    sel_rw    = issue_id ? rw1    : rw0;
    sel_addr  = issue_id ? addr1  : addr0;
    sel_wdata = issue_id ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      prio           <= 1'b0;
      ram_enable     <= 1'b0;
      ram_read_write <= 1'b0;
      ram_addr       <= '0;
      ram_data_in    <= '0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      grant_id       <= 1'b0;
      rd_valid       <= 1'b0;
      rd_id          <= 1'b0;
    end else begin
      state      <= state_next;
      prio       <= prio_next;
      ram_enable <= issue;
      ack0       <= issue && !issue_id;
      ack1       <= issue && issue_id;
      if (issue) begin
        ram_read_write <= sel_rw;
        ram_addr       <= sel_addr;
        ram_data_in    <= sel_wdata;
        grant_id       <= issue_id;
      end
      // RAM read data appears one cycle after the strobe; tag it with the owner.
      rd_valid <= ram_enable && !ram_read_write;
      if (ram_enable && !ram_read_write)
        rd_id <= grant_id;
    end
  end

  always_comb begin
    rd_data = rd_valid ? ram_data_out : '0;
  end

  a_one_ack : assert property (@(posedge clk) !(ack0 && ack1));

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by randomized
// requester traffic, checked against a transaction-level reference model.
module tb_ram_arbiter;

  localparam int N  = 32;
  localparam int DW = 32;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_v = '0;
  logic [1:0]    lock_v = '0;
  logic [1:0]    rw_v = '0;
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] wdata_v [2];
  logic          ack0, ack1, rd_valid, rd_id;
  logic [DW-1:0] rd_data;
  logic          ram_enable, ram_read_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic [DW-1:0] mem [N];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  ram_arbiter #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req_v[0]), .req1(req_v[1]),
    .lock0(lock_v[0]), .lock1(lock_v[1]),
    .rw0(rw_v[0]), .rw1(rw_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]),
    .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
    .ack0(ack0), .ack1(ack1),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .ram_enable(ram_enable), .ram_read_write(ram_read_write),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_read_write) mem[ram_addr] <= ram_data_in;
      else                ram_data_out  <= mem[ram_addr];
    end
  end

  // Reference model: who holds the grant, whose turn it is, and what memory holds.
  int            holder = -1;
  int            turn = 0;
  logic          e_en = 0, e_rw = 0, e_ack0 = 0, e_ack1 = 0;
  logic          e_rdv = 0, e_rdid = 0, e_rst = 0, e_known = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0, e_rdd = '0;
  logic          p_id = 0, p_known = 0;
  logic [DW-1:0] p_data = '0;
  logic [DW-1:0] shadow [int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int win;
    if (reset) begin
      holder = -1; turn = 0;
      e_en = 0; e_rw = 0; e_addr = '0; e_wd = '0;
      e_ack0 = 0; e_ack1 = 0; e_rdv = 0; e_rdid = 0; e_rdd = '0;
      e_known = 1; e_rst = 1;
      return;
    end
    e_rst = 0;
    e_rdv = e_en && !e_rw;
    if (e_rdv) begin
      e_rdid = p_id; e_rdd = p_data; e_known = p_known;
    end
    win = -1;
    if (holder >= 0) begin
      if (req_v[holder] && lock_v[holder]) win = holder;
      else turn = 1 - holder;
    end else if (req_v[0] && req_v[1]) win = turn;
    else if (req_v[0]) win = 0;
    else if (req_v[1]) win = 1;
    holder = win;
    e_en   = (win >= 0);
    e_ack0 = (win == 0);
    e_ack1 = (win == 1);
    if (win >= 0) begin
      e_rw   = rw_v[win];
      e_addr = addr_v[win];
      e_wd   = wdata_v[win];
      p_id   = (win == 1);
      if (e_rw) shadow[int'(e_addr)] = e_wd;
      else begin
        p_known = shadow.exists(int'(e_addr));
        if (p_known) p_data = shadow[int'(e_addr)];
      end
    end
  endtask

  task automatic compare();
    check("one_ack", ack0 && ack1, 0);
    check("ack0", ack0, e_ack0);
    check("ack1", ack1, e_ack1);
    check("ram_enable", ram_enable, e_en);
    check("rd_valid", rd_valid, e_rdv);
    if (e_en || e_rst) begin
      check("ram_rw", ram_read_write, e_rw);
      check("ram_addr", ram_addr, e_addr);
      check("ram_data_in", ram_data_in, e_wd);
    end
    if (e_rdv || e_rst) check("rd_id", rd_id, e_rdid);
    if (e_rst || (e_rdv && e_known)) check("rd_data", rd_data, e_rdd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    req_v = '0; lock_v = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_access(input int r, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    req_v[r] = 1'b1; rw_v[r] = rw; addr_v[r] = a; wdata_v[r] = d;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = (r == 1) ? ack1 : ack0;
    end
    check("ack_wait", got, 1);
    check("acc_addr", ram_addr, a);
    check("acc_rw", ram_read_write, rw);
    req_v[r] = 1'b0;
  endtask

  initial begin
    int run, t;
    for (int r = 0; r < 2; r++) begin
      addr_v[r] = '0; wdata_v[r] = '0;
    end
    tick(); tick();
    reset = 1'b0;

    // Write from requester 0, then read it back through requester 1.
    do_access(0, 1'b1, AW'(8'h10), 32'hDEADBEEF);
    tick();
    check("w_no_rdv", rd_valid, 0);
    do_access(1, 1'b0, AW'(8'h10), '0);
    tick();
    check("r1_rdv", rd_valid, 1);
    check("r1_id", rd_id, 1);
    check("r1_data", rd_data, 32'hDEADBEEF);

    do_access(0, 1'b1, AW'(3), 32'h55);
    tick();
    do_access(0, 1'b0, AW'(3), '0);
    tick();
    check("r0_data", rd_data, 32'h55);
    check("r0_id", rd_id, 0);

    // Both requesting without lock: strict alternation with an idle gap.
    do_reset();
    req_v = 2'b11; lock_v = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("alt_ack0", ack0, (i % 4) == 1);
      check("alt_ack1", ack1, (i % 4) == 3);
    end
    req_v = '0;
    tick(); tick();

    // Locked burst of four from requester 0 while requester 1 waits.
    do_reset();
    req_v = 2'b11; lock_v = 2'b01;
    run = 0; t = 0;
    while (run < 4 && t < 10) begin
      tick();
      t++;
      if (ack0) run++;
    end
    check("lock_ticks", t, 4);
    req_v[0] = 1'b0; lock_v[0] = 1'b0;
    tick();
    check("lock_gap", ack0 || ack1, 0);
    tick();
    check("lock_then_ack1", ack1, 1);
    req_v = '0;
    tick(); tick();

    // Reset landing right after a read strobe kills the pending rd_valid.
    do_reset();
    req_v[1] = 1'b1; rw_v[1] = 1'b0; addr_v[1] = AW'(8'h10);
    tick();
    check("rst_strobe", ack1, 1);
    req_v[1] = 1'b0; reset = 1'b1;
    tick();
    check("rst_rdv", rd_valid, 0);
    check("rst_en", ram_enable, 0);
    reset = 1'b0;
    req_v = 2'b11;
    tick();
    check("rst_prio", ack0, 1);
    req_v = '0;
    tick(); tick();

    // Randomized traffic obeying the hold-until-ack protocol.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 63) == 0);
      for (int r = 0; r < 2; r++) begin
        logic a;
        a = (r == 1) ? ack1 : ack0;
        if (!(req_v[r] && !a)) begin
          req_v[r]   = ($urandom_range(0, 99) < 60);
          lock_v[r]  = ($urandom_range(0, 99) < 50);
          rw_v[r]    = $urandom_range(0, 1);
          addr_v[r]  = AW'($urandom_range(0, N - 1));
          wdata_v[r] = $urandom;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
